// File: rtl/shared_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// shared_mem_arbiter_if
//   Bundles the three buses around shared_mem_arbiter:
//     fetch side (if_*)  : read-only requester, req/addr in, gnt/rvalid/rdata out
//     load/store (ls_*)  : read/write requester, req/we/addr/wdata in,
//                          gnt/rvalid/rdata out
//     memory (mem_*)     : single-port synchronous RAM command and read data
//     busy               : arbiter has an access in flight
//   Modports:
//     slave  - the arbiter: requester and memory-read inputs, everything else out
//     master - the surrounding fabric: the reverse view
// ----------------------------------------------------------------------------
interface shared_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    // Fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // Load/store requester
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

    // Unified RAM
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Status
    logic          busy;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// ----------------------------------------------------------------------------
// shared_mem_arbiter
//   Shares one single-port synchronous RAM between the fetch requester (IF)
//   and the load/store requester (LS). One access is in flight at a time;
//   when both requesters ask together the one not granted last wins.
//   Every output is a flop, including the read-data return path.
//
//   Access timeline (ISSUE in cycle t):
//     t                : mem_en, mem_we/addr/wdata and the winner's gnt
//     t+1 .. t+MEM_LAT : WAIT, mem_rdata captured at the end of t+MEM_LAT
//     t+MEM_LAT+1      : RESP, winner's rvalid; next grant may be decided here
//
//   Ports:
//     clk    in  rising-edge clock
//     Reset  in  synchronous, active-high reset
//     bus    slave modport of shared_mem_arbiter_if (if_*, ls_*, mem_*, busy)
//   Parameters:
//     AW      word-address width
//     DW      data width
//     MEM_LAT RAM read latency in cycles, 1..4
// ----------------------------------------------------------------------------
module shared_mem_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 Reset,
    shared_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    // WAIT lasts MEM_LAT cycles; the counter runs MEM_LAT-1 down to 0.
    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_e        state_q,     state_d;
    logic [2:0]    cnt_q,       cnt_d;
    logic          prio_ls_q,   prio_ls_d;   // 1: LS wins a tie
    logic          sel_ls_q,    sel_ls_d;    // requester owning the access
    logic          store_q,     store_d;     // access in flight is a store

    logic          if_gnt_q,    if_gnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic          ls_gnt_q,    ls_gnt_d;
    logic          ls_rvalid_q, ls_rvalid_d;
    logic [DW-1:0] ls_rdata_q,  ls_rdata_d;
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          busy_q,      busy_d;

    logic          any_req;
    logic          pick_ls;

    // A lone requester always wins; on a tie the round-robin pointer decides.
    assign any_req = bus.if_req | bus.ls_req;
    assign pick_ls = bus.ls_req & (~bus.if_req | prio_ls_q);

    always_comb begin
        // NOTE: every _d is given its hold/idle value first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_ls_d   = prio_ls_q;
        sel_ls_d    = sel_ls_q;
        store_d     = store_q;
        if_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_gnt_d    = 1'b0;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            // Arbitration happens only here; requests seen in ISSUE/WAIT
            // are ignored so a held request cannot be granted twice.
            S_IDLE, S_RESP: begin
                if (any_req) begin
                    state_d   = S_ISSUE;
                    sel_ls_d  = pick_ls;
                    prio_ls_d = ~pick_ls;
                    mem_en_d  = 1'b1;
                    if (pick_ls) begin
                        ls_gnt_d    = 1'b1;
                        store_d     = bus.ls_we;
                        mem_we_d    = bus.ls_we;
                        mem_addr_d  = bus.ls_addr;
                        mem_wdata_d = bus.ls_wdata;
                    end else begin
                        if_gnt_d    = 1'b1;
                        store_d     = 1'b0;
                        mem_addr_d  = bus.if_addr;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = LAT_LAST;
            end

            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                    if (sel_ls_q) begin
                        ls_rvalid_d = 1'b1;
                        // A store is only acknowledged; load data stays put.
                        if (!store_q) begin
                            ls_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prio_ls_q   <= 1'b1;
            sel_ls_q    <= 1'b0;
            store_q     <= 1'b0;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_gnt_q    <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_ls_q   <= prio_ls_d;
            sel_ls_q    <= sel_ls_d;
            store_q     <= store_d;
            if_gnt_q    <= if_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_gnt_q    <= ls_gnt_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_gnt    = ls_gnt_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shared_mem_arbiter
//   Two arbiters on one clock and reset: dut1 with MEM_LAT=1 and dut3 with
//   MEM_LAT=3, each attached to its own behavioural RAM whose read data is
//   non-zero only in the exact cycle MEM_LAT after mem_en.
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_shared_mem_arbiter;
    logic clk;
    logic Reset;

    int checks = 0;
    int errors = 0;

    shared_mem_arbiter_if #(.AW(10), .DW(32)) b1 ();
    shared_mem_arbiter_if #(.AW(10), .DW(32)) b3 ();

    shared_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1)) dut1 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (b1)
    );

    shared_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3)) dut3 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAMs with a preload port
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] rd1;
    logic [31:0] p3_0, p3_1, p3_2;

    always @(posedge clk) begin
        if (pre_we) mem1[pre_addr] <= pre_data;
        else if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
        rd1 <= b1.mem_en ? mem1[b1.mem_addr] : 32'h0;
    end

    always @(posedge clk) begin
        if (pre_we) mem3[pre_addr] <= pre_data;
        else if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
        p3_0 <= b3.mem_en ? mem3[b3.mem_addr] : 32'h0;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end

    assign b1.mem_rdata = rd1;
    assign b3.mem_rdata = p3_2;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset, including requests presented while Reset is high
    task automatic test_reset();
        logic [112:0] got;
        Reset = 1'b1;
        b1.if_req = 1'b1; b1.if_addr = 10'h005;
        b1.ls_req = 1'b1; b1.ls_we = 1'b0; b1.ls_addr = 10'h020;
        cyc(2);
        got = {b1.if_gnt, b1.if_rvalid, b1.if_rdata, b1.ls_gnt, b1.ls_rvalid,
               b1.ls_rdata, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.busy};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", got);
        end
        checks++;
        if ({b3.busy, b3.mem_en, b3.ls_gnt, b3.if_gnt} !== 4'b0) begin
            errors++;
            $display("FAIL reset_dut3: got %b required 0000",
                     {b3.busy, b3.mem_en, b3.ls_gnt, b3.if_gnt});
        end
        b1.if_req = 1'b0; b1.ls_req = 1'b0;
        cyc(1);
    endtask

    // MEM_LAT=1 fetch read of 0x005
    task automatic test_if_read();
        Reset = 1'b0;
        b1.if_req = 1'b1; b1.if_addr = 10'h005;
        cyc(1);
        checks++;
        if ({b1.if_gnt, b1.mem_en, b1.mem_we, b1.mem_addr, b1.busy} !== {3'b110, 10'h005, 1'b1}) begin
            errors++;
            $display("FAIL if_issue: got gnt/en/we/addr/busy %b required 110/005/1",
                     {b1.if_gnt, b1.mem_en, b1.mem_we, b1.mem_addr, b1.busy});
        end
        cyc(1);
        checks++;
        if ({b1.if_gnt, b1.if_rvalid, b1.mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL if_wait: got gnt/rvalid/en %b required 000",
                     {b1.if_gnt, b1.if_rvalid, b1.mem_en});
        end
        b1.if_req = 1'b0;
        cyc(1);
        checks++;
        if ({b1.if_rvalid, b1.ls_rvalid, b1.if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL if_resp: got rvalid if/ls %b rdata %h required 10 DEADBEEF",
                     {b1.if_rvalid, b1.ls_rvalid}, b1.if_rdata);
        end
        cyc(1);
        checks++;
        if ({b1.busy, b1.if_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL if_idle: got busy/rvalid %b required 00", {b1.busy, b1.if_rvalid});
        end
    endtask

    // MEM_LAT=1 store then load of 0x020
    task automatic test_store_load();
        b1.ls_req = 1'b1; b1.ls_we = 1'b1; b1.ls_addr = 10'h020; b1.ls_wdata = 32'h12345678;
        cyc(1);
        checks++;
        if ({b1.ls_gnt, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !==
            {3'b111, 10'h020, 32'h12345678}) begin
            errors++;
            $display("FAIL store_issue: got gnt/en/we %b addr %h wdata %h required 111 020 12345678",
                     {b1.ls_gnt, b1.mem_en, b1.mem_we}, b1.mem_addr, b1.mem_wdata);
        end
        cyc(1);
        b1.ls_we = 1'b0; b1.ls_wdata = 32'h0;
        cyc(1);
        checks++;
        if ({b1.ls_rvalid, b1.if_rvalid, b1.ls_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL store_ack: got rvalid ls/if %b rdata %h required 10 00000000",
                     {b1.ls_rvalid, b1.if_rvalid}, b1.ls_rdata);
        end
        cyc(1);
        checks++;
        if ({b1.ls_gnt, b1.mem_en, b1.mem_we} !== 3'b110) begin
            errors++;
            $display("FAIL load_issue: got gnt/en/we %b required 110",
                     {b1.ls_gnt, b1.mem_en, b1.mem_we});
        end
        cyc(1);
        b1.ls_req = 1'b0;
        cyc(1);
        checks++;
        if ({b1.ls_rvalid, b1.ls_rdata, b1.if_rdata} !== {1'b1, 32'h12345678, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_resp: got rvalid %b ls_rdata %h if_rdata %h required 1 12345678 DEADBEEF",
                     b1.ls_rvalid, b1.ls_rdata, b1.if_rdata);
        end
        cyc(1);
    endtask

    // Both requesters held out of reset: LS, IF, LS, IF, ISSUE every 3 cycles
    task automatic test_round_robin();
        logic [4:0] got, exp;
        int ph, n;
        bit ls_turn;
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        b1.if_req = 1'b1; b1.if_addr = 10'h005;
        b1.ls_req = 1'b1; b1.ls_we = 1'b0; b1.ls_addr = 10'h020;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            ph = (k - 1) % 3;
            n = (k - 1) / 3;
            ls_turn = (n % 2 == 0);
            exp = {ph == 0 && !ls_turn, ph == 0 && ls_turn, ph == 0,
                   ph == 2 && !ls_turn, ph == 2 && ls_turn};
            got = {b1.if_gnt, b1.ls_gnt, b1.mem_en, b1.if_rvalid, b1.ls_rvalid};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rr_cycle%0d: got ifg/lsg/en/ifv/lsv %b required %b", k, got, exp);
            end
            if (ph == 2) begin
                checks++;
                if (ls_turn ? (b1.ls_rdata !== 32'h12345678) : (b1.if_rdata !== 32'hDEADBEEF)) begin
                    errors++;
                    $display("FAIL rr_data%0d: got ls %h if %h", k, b1.ls_rdata, b1.if_rdata);
                end
            end
        end
        b1.if_req = 1'b0; b1.ls_req = 1'b0;
        cyc(1);
        checks++;
        if (b1.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got busy %b required 0", b1.busy);
        end
    endtask

    // Reset during WAIT kills the access; the next request is served normally
    task automatic test_reset_mid();
        logic [112:0] got;
        b1.if_req = 1'b1; b1.if_addr = 10'h005;
        cyc(2);
        b1.if_req = 1'b0;
        Reset = 1'b1;
        cyc(1);
        got = {b1.if_gnt, b1.if_rvalid, b1.if_rdata, b1.ls_gnt, b1.ls_rvalid,
               b1.ls_rdata, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.busy};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h required 0", got);
        end
        Reset = 1'b0;
        b1.ls_req = 1'b1; b1.ls_we = 1'b0; b1.ls_addr = 10'h020;
        cyc(1);
        checks++;
        if ({b1.ls_gnt, b1.if_gnt, b1.mem_en} !== 3'b101) begin
            errors++;
            $display("FAIL reset_mid_regrant: got lsg/ifg/en %b required 101",
                     {b1.ls_gnt, b1.if_gnt, b1.mem_en});
        end
        cyc(1);
        b1.ls_req = 1'b0;
        cyc(1);
        checks++;
        if ({b1.ls_rvalid, b1.if_rvalid, b1.ls_rdata} !== {2'b10, 32'h12345678}) begin
            errors++;
            $display("FAIL reset_mid_resp: got rvalid ls/if %b rdata %h required 10 12345678",
                     {b1.ls_rvalid, b1.if_rvalid}, b1.ls_rdata);
        end
        cyc(1);
    endtask

    // MEM_LAT=3 load with the request held through WAIT
    task automatic test_lat3_load();
        logic [3:0] got, exp;
        b3.ls_req = 1'b1; b3.ls_we = 1'b0; b3.ls_addr = 10'h030;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            exp = {k == 1, k == 1, k == 5, k <= 5};
            got = {b3.ls_gnt, b3.mem_en, b3.ls_rvalid, b3.busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lat3_cycle%0d: got gnt/en/rvalid/busy %b required %b", k, got, exp);
            end
            if (k == 5) begin
                checks++;
                if (b3.ls_rdata !== 32'hCAFEF00D) begin
                    errors++;
                    $display("FAIL lat3_data: got %h required CAFEF00D", b3.ls_rdata);
                end
                b3.ls_req = 1'b0;
            end
        end
    endtask

    // MEM_LAT=3: IF request arriving mid-LS is granted from RESP
    task automatic test_if_during_ls();
        logic [5:0] got, exp;
        b3.ls_req = 1'b1; b3.ls_we = 1'b0; b3.ls_addr = 10'h030;
        for (int k = 1; k <= 11; k++) begin
            cyc(1);
            exp = {k == 6, k == 1, k == 1 || k == 6, k == 10, k == 5, k <= 10};
            got = {b3.if_gnt, b3.ls_gnt, b3.mem_en, b3.if_rvalid, b3.ls_rvalid, b3.busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_if_cycle%0d: got ifg/lsg/en/ifv/lsv/busy %b required %b", k, got, exp);
            end
            if (k == 2) begin
                b3.ls_req = 1'b0;
                b3.if_req = 1'b1; b3.if_addr = 10'h031;
            end
            if (k == 6) b3.if_req = 1'b0;
            if (k == 10) begin
                checks++;
                if (b3.if_rdata !== 32'h0BADF00D) begin
                    errors++;
                    $display("FAIL mid_if_data: got %h required 0BADF00D", b3.if_rdata);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        b1.if_req = 1'b0; b1.if_addr = '0;
        b1.ls_req = 1'b0; b1.ls_we = 1'b0; b1.ls_addr = '0; b1.ls_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0;
        b3.ls_req = 1'b0; b3.ls_we = 1'b0; b3.ls_addr = '0; b3.ls_wdata = '0;

        pre_we = 1'b1; pre_addr = 10'h005; pre_data = 32'hDEADBEEF;
        cyc(1);
        pre_addr = 10'h020; pre_data = 32'hA5A5A5A5;
        cyc(1);
        pre_addr = 10'h030; pre_data = 32'hCAFEF00D;
        cyc(1);
        pre_addr = 10'h031; pre_data = 32'h0BADF00D;
        cyc(1);
        pre_we = 1'b0;

        test_reset();
        test_if_read();
        test_store_load();
        test_round_robin();
        test_reset_mid();
        test_lat3_load();
        test_if_during_ls();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
